// File: rtl/unified_mem_arbiter.sv
// Unified I/D word memory behind a req/ack arbiter: ack at T+LATENCY+2, requesters stall until ack.
// Defining IFETCH_BUF_EN adds a one-entry fetch buffer (hit in IDLE with no D request -> ack at T+1).
module unified_mem_arbiter #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_sel,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              last_d_q;
    logic              gnt_d_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [DEPTH];

    logic              grant_d_w, grant_i_w, hit_w, fast_w, commit_w, oor_q_w;
    logic [IDX_W-1:0]  idx_q_w;
    logic [31:0]       buf_dat_w;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> (IDX_W + 2)) != '0;
    endfunction

    // Alternate on contention; last_d_q=0 means I was granted last.
    assign grant_d_w = d_req && (!i_req || !last_d_q);
    assign grant_i_w = i_req && !grant_d_w;
    assign fast_w    = grant_i_w && hit_w && !d_req;
    assign commit_w  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign oor_q_w   = out_of_range(addr_q);
    assign idx_q_w   = addr_q[2 +: IDX_W];

`ifdef IFETCH_BUF_EN
    logic             buf_vld_q;
    logic [IDX_W-1:0] buf_tag_q;
    logic [31:0]      buf_inst_q;

    assign hit_w     = i_req && !out_of_range(i_addr) && buf_vld_q
                       && (buf_tag_q == i_addr[2 +: IDX_W]);
    assign buf_dat_w = buf_inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld_q  <= 1'b0;
            buf_tag_q  <= '0;
            buf_inst_q <= '0;
        end else if (commit_w && !oor_q_w) begin
            if (!gnt_d_q) begin
                buf_vld_q  <= 1'b1;
                buf_tag_q  <= idx_q_w;
                buf_inst_q <= mem_q[idx_q_w];
            end else if (we_q && buf_tag_q == idx_q_w) begin
                buf_vld_q  <= 1'b0;
            end
        end
    end
`else
    assign hit_w     = 1'b0;
    assign buf_dat_w = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fast_w) begin
                    state_d = ST_RESP;
                end else if (grant_d_w || grant_i_w) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i_ack   = (state_q == ST_RESP) && !gnt_d_q;
        d_ack   = (state_q == ST_RESP) && gnt_d_q;
        i_rdata = i_ack ? rdata_q : 32'd0;
        d_rdata = d_ack ? rdata_q : 32'd0;
        d_err   = d_ack && oor_q_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            last_d_q <= 1'b0;
            gnt_d_q  <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_d_w || grant_i_w) begin
                        gnt_d_q <= grant_d_w;
                        addr_q  <= grant_d_w ? d_addr : i_addr;
                        we_q    <= grant_d_w && d_we;
                        sel_q   <= d_sel;
                        wdata_q <= d_wdata;
                        cnt_q   <= LAT4;
                        if (fast_w) begin
                            rdata_q <= buf_dat_w;
                        end else begin
                            last_d_q <= grant_d_w;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (we_q || oor_q_w) begin
                        rdata_q <= 32'd0;
                    end else begin
                        rdata_q <= mem_q[idx_q_w];
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset forces state_q to IDLE asynchronously, so a pending store never commits.
    always_ff @(posedge clk) begin
        if (commit_w && we_q && !oor_q_w) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem_q[idx_q_w][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter (LATENCY=2); define IFETCH_BUF_EN to cover the fetch buffer.
module tb_unified_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_sel = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    unified_mem_arbiter #(.DEPTH(1024), .ADDR_W(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;   // 1 = D
        logic        chkd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] model [1024];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        prev_i = 1'b0, prev_d = 1'b0;
    logic        sp_on = 1'b0, sp_have = 1'b0;
    int          sp_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        return a[31:12] != '0;
    endfunction

    // Scoreboard consumer: every ack pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_i) check_val("i_ack_width", {31'd0, i_ack}, 32'd0);
                if (prev_d) check_val("d_ack_width", {31'd0, d_ack}, 32'd0);
                if (i_ack || d_ack) begin
                    check_val("ack_both", {31'd0, i_ack && d_ack}, 32'd0);
                    if (expq.size() == 0) begin
                        check_val("ack_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check_val("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                        if (e.chkd) check_val("rdata", d_ack ? d_rdata : i_rdata, e.data);
                        check_val("d_err", {31'd0, d_err}, {31'd0, e.err});
                    end
                    if (sp_on && sp_have) check_val("ack_spacing", cyc - sp_last, LAT + 3);
                    sp_have = 1'b1;
                    sp_last = cyc;
                end
            end
            prev_i = i_ack;
            prev_d = d_ack;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
        check_val({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
        check_val({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
        check_val({tag, "_i_rdata"}, i_rdata, 32'd0);
        check_val({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    task automatic d_op(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata);
        exp_t e;
        int   start;
        bit   got;
        e.port = 1'b1;
        e.err  = is_oor(addr);
        e.chkd = !we;
        e.data = (we || is_oor(addr)) ? 32'd0 : model[addr[11:2]];
        if (we && !is_oor(addr))
            for (int b = 0; b < 4; b++)
                if (sel[b]) model[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
        expq.push_back(e);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_addr = addr; d_sel = sel; d_wdata = wdata;
        start = cyc;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1;
                check_val("d_latency", cyc - start, LAT + 2);
            end
        end
        if (!got) check_val("d_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic i_op(input logic [31:0] addr, input int exp_lat);
        exp_t e;
        int   start;
        bit   got;
        e.port = 1'b0;
        e.err  = 1'b0;
        e.chkd = 1'b1;
        e.data = is_oor(addr) ? 32'd0 : model[addr[11:2]];
        expq.push_back(e);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = addr;
        start = cyc;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (i_ack) begin
                got = 1'b1;
                check_val("i_latency", cyc - start, exp_lat);
            end
        end
        if (!got) check_val("i_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        check_outputs_zero("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("rst_rel");

        d_op(1'b1, 32'h0, 4'hF, 32'h0BADF00D);
        d_op(1'b1, 32'h40, 4'hF, 32'h01020304);

        // Isolated fetch: ack exactly LAT+2 cycles after the IDLE sample.
        i_op(32'h0, LAT + 2);

        // Reset in the middle of WAIT for a store: store must be lost.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_sel = 4'hF; d_wdata = 32'hDEADBEEF;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check_outputs_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("rst_after");
        d_op(1'b0, 32'h40, 4'h0, 32'h0);

        // Byte-masked store.
        d_op(1'b1, 32'h10, 4'hF, 32'h11223344);
        d_op(1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
        check_val("byte_model", model[4], 32'h11BB33DD);
        d_op(1'b0, 32'h10, 4'h0, 32'h0);

        // d_sel=0 store is a no-op but still acked.
        d_op(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF);
        d_op(1'b0, 32'h10, 4'h0, 32'h0);

        // Out-of-range accesses.
        d_op(1'b0, 32'h1000, 4'h0, 32'h0);
        d_op(1'b1, 32'h1000, 4'hF, 32'hCAFEBABE);
        d_op(1'b0, 32'h0, 4'h0, 32'h0);
        i_op(32'h1004, LAT + 2);

`ifdef IFETCH_BUF_EN
        d_op(1'b1, 32'h20, 4'hF, 32'h12345678);
        i_op(32'h20, LAT + 2);
        i_op(32'h20, 1);
        d_op(1'b1, 32'h20, 4'hF, 32'h87654321);
        i_op(32'h20, LAT + 2);
        i_op(32'h20, 1);
`endif

        // Contention with last grant = I: expect D, I, D, I at LAT+3 spacing.
        i_op(32'h10, LAT + 2);
        for (int k = 0; k < 4; k++) begin
            e.port = (k % 2 == 0);
            e.chkd = 1'b1;
            e.err  = 1'b0;
            e.data = e.port ? model[16] : model[4];
            expq.push_back(e);
        end
        sp_have = 1'b0;
        sp_on   = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_sel = 4'h0;
        n = 0;
        for (int k = 0; k < 200 && n < 4; k++) begin
            @(negedge clk);
            if (i_ack || d_ack) n++;
        end
        check_val("contention_acks", n, 4);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        sp_on = 1'b0;
        repeat (8) @(negedge clk);
        check_val("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
